// File: rtl/if_fetch_stage_pkg.sv
// Shared RV32I types for the fetch stage: FSM state encoding, bubble opcode and reset vector.
package rv32i_types;

  typedef enum logic [1:0] {FETCH, HOLD, DROP} if_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0060;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect inputs, imem port and IF/ID outputs.
// Perf counter signals exist only when IF_FETCH_PERF_EN is defined.
interface if_fetch_stage_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        if_id_load;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_killed;
  logic [31:0] perf_stall_cycles;
`endif

  modport master (
    input  stall, redirect, redirect_pc, imem_resp, imem_rdata,
`ifdef IF_FETCH_PERF_EN
    output perf_fetched, perf_killed, perf_stall_cycles,
`endif
    output imem_read, imem_address, instr_out, pc_out, valid_out, if_id_load
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_resp, imem_rdata,
`ifdef IF_FETCH_PERF_EN
    input  perf_fetched, perf_killed, perf_stall_cycles,
`endif
    input  imem_read, imem_address, instr_out, pc_out, valid_out, if_id_load
  );
endinterface

// File: rtl/if_fetch_stage_pc_reg.sv
// Program counter register: redirect (word aligned) wins over increment; otherwise holds.
module if_pc_reg
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        inc,
  input  logic [31:0] inc_base,
  output logic [31:0] pc
);

  logic [31:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = word_align(redirect_pc);
    end else if (inc) begin
      pc_d = inc_base + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// RV32I instruction fetch stage: PC ownership, imem requests, stall hold buffer and redirect drop.
// Optional perf counters are enabled with the IF_FETCH_PERF_EN macro.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = rv32i_types::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = rv32i_types::NOP_INSTR
) (
  input logic            clk,
  input logic            rst_n,
  if_fetch_stage_if.master bus
);
  import rv32i_types::*;

  if_state_t   state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] pc, pc_inc_base, target;
  logic        pc_inc, discard, read_req;

  assign target = word_align(bus.redirect_pc);

  if_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .redirect   (bus.redirect),
    .redirect_pc(bus.redirect_pc),
    .inc        (pc_inc),
    .inc_base   (pc_inc_base),
    .pc         (pc)
  );

  always_comb begin
    state_d       = state_q;
    req_addr_d    = req_addr_q;
    buf_instr_d   = buf_instr_q;
    buf_pc_d      = buf_pc_q;
    pc_inc        = 1'b0;
    pc_inc_base   = req_addr_q;
    discard       = 1'b0;
    read_req      = 1'b1;
    bus.instr_out = NOP_INSTR;
    bus.pc_out    = req_addr_q;
    bus.valid_out = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (bus.redirect) begin
          if (bus.imem_resp) begin
            discard    = 1'b1;
            req_addr_d = target;
          end else begin
            state_d = DROP;
          end
        end else if (bus.imem_resp) begin
          bus.instr_out = bus.imem_rdata;
          bus.valid_out = 1'b1;
          if (!bus.stall) begin
            pc_inc     = 1'b1;
            req_addr_d = req_addr_q + 32'd4;
          end else begin
            buf_instr_d = bus.imem_rdata;
            buf_pc_d    = req_addr_q;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        read_req = 1'b0;
        if (bus.redirect) begin
          discard    = 1'b1;
          req_addr_d = target;
          state_d    = FETCH;
        end else begin
          bus.instr_out = buf_instr_q;
          bus.pc_out    = buf_pc_q;
          bus.valid_out = 1'b1;
          if (!bus.stall) begin
            pc_inc      = 1'b1;
            pc_inc_base = buf_pc_q;
            req_addr_d  = buf_pc_q + 32'd4;
            state_d     = FETCH;
          end
        end
      end
      DROP: begin
        // The stale response is consumed here; pc already holds the newest target.
        if (bus.imem_resp) begin
          discard    = 1'b1;
          req_addr_d = bus.redirect ? target : pc;
          state_d    = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign bus.imem_read    = read_req & rst_n;
  assign bus.imem_address = req_addr_q;
  assign bus.if_id_load   = ~bus.stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      req_addr_q  <= RESET_PC;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_killed_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_killed_q  <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (bus.valid_out && bus.if_id_load) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (discard)                         perf_killed_q  <= perf_killed_q + 32'd1;
      if (bus.stall)                       perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign bus.perf_fetched      = perf_fetched_q;
  assign bus.perf_killed       = perf_killed_q;
  assign bus.perf_stall_cycles = perf_stall_q;
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction fetch stage of the RV32I pipeline. It owns the PC, issues requests to the instruction memory port, and hands {instr, pc, valid} plus a load strobe to the IF/ID pipeline register. It honours back-pressure from the hazard unit (stall) and PC redirects from the writeback-stage PC-mux select. A redirect discards any response still in flight.

Parameters:
RESET_PC, 32'h0000_0060, PC value loaded at reset.
NOP_INSTR, 32'h0000_0013, instruction driven on bubbles (addi x0,x0,0).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  downstream (IF/ID) cannot accept this cycle
redirect  in  1  take redirect_pc (jal/jalr/taken branch)
redirect_pc  in  32  redirect target
imem_read  out  1  instruction memory request
imem_address  out  32  request address, word aligned
imem_resp  in  1  response valid, single-cycle pulse
imem_rdata  in  32  fetched instruction
instr_out  out  32  to IF/ID instr_in
pc_out  out  32  to IF/ID pc_in
valid_out  out  1  instr_out is a real instruction
if_id_load  out  1  IF/ID load strobe

Behaviour:
- Registers: pc (next fetch address), req_addr (outstanding request address), buf_instr/buf_pc (hold buffer), state.
- Reset (async, rst_n=0): pc=RESET_PC, req_addr=RESET_PC, state=FETCH, buffers=0. imem_read=0 while rst_n=0; imem_read=1 from the first edge after deassertion.
- States: FETCH, HOLD, DROP.
- FETCH:
  - imem_read=1; imem_address=req_addr, held stable until imem_resp.
  - resp & !redirect & !stall: instr_out=imem_rdata, pc_out=req_addr (combinational), valid_out=1, if_id_load=1. pc and req_addr <= req_addr+4. Stay in FETCH. The back-to-back request issues the next cycle.
  - resp & !redirect & stall: capture rdata/req_addr into buffer and go to HOLD. if_id_load=0.
  - !resp & !stall: bubble, with instr_out=NOP_INSTR, valid_out=0, if_id_load=1.
  - !resp & stall: if_id_load=0.
- HOLD:
  - imem_read=0. Outputs come from the buffer with valid_out=1.
  - if_id_load = !stall.
  - On !stall: pc and req_addr <= buf_pc+4, go to FETCH.
- DROP:
  - imem_read=1 at the old req_addr. Outputs are a bubble, and if_id_load = !stall.
  - On resp: discard rdata, req_addr <= pc, go to FETCH.
- Redirect has priority over everything in every state:
  - pc <= {redirect_pc[31:2],2'b00}.
  - Same-cycle resp, or HOLD: discard, req_addr <= target, go to FETCH.
  - FETCH with no resp: go to DROP.
  - DROP: target updates, remain in DROP.
  - During a redirect cycle, valid_out=0 and instr_out=NOP_INSTR. if_id_load = !stall.
- Stall and redirect together: redirect is taken and the IF/ID load is suppressed.
- Arithmetic: PC increment is modulo 2^32, so 32'hFFFF_FFFC+4 = 0.
- Latency: a response is presented to IF/ID in the same cycle as imem_resp. Maximum throughput is one instruction per cycle under a single-cycle memory.

Optional Feature:
IF_FETCH_PERF_EN
- Defined: adds three 32-bit outputs, all reset to 0 and wrapping:
  - perf_fetched: increments on each valid if_id_load.
  - perf_killed: increments on each discarded response.
  - perf_stall_cycles: increments on each cycle with stall=1.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- rv32i_types package gains:
  - if_state_t enum {FETCH, HOLD, DROP}.
  - Constants NOP_INSTR = 32'h13 and RESET_PC_DEFAULT.
- One sub-module: if_pc_reg, holding the PC register with load/increment/redirect select and async reset.
- The FSM and output muxing stay in if_fetch_stage.

Test Plan:
- Reset release, imem_resp every cycle with rdata = address: imem_address sequence 0x60, 0x64, 0x68. if_id_load=1 with valid_out=1 each cycle, pc_out matching.
- resp at 0x64 while stall=1 for 3 cycles: state HOLD and imem_read=0. instr_out/pc_out stay 0x64 with if_id_load=0. When stall drops, load the 0x64 instruction, then the next request goes to 0x68.
- redirect to 0x200 while request 0x68 is outstanding with no resp: enter DROP with imem_address held at 0x68. The resp for 0x68 is discarded (valid_out=0), then the next request goes to 0x200.
- redirect to 0x300 in the same cycle as resp: rdata discarded, next imem_address=0x300, no DROP.
- redirect_pc=0x203: fetch at 0x200. PC at 0xFFFFFFFC with resp: next address 0x0.
- rst_n asserted mid-DROP: immediately imem_read=0 and state FETCH. After release, the request goes to 0x60. With IF_FETCH_PERF_EN, counters read 0.
